// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline controller.
//   state_t        : controller FSM states (RUN / STALL / DRAIN)
//   IF_ID..MEM_WB  : bit positions of each pipeline boundary in ok/flush vectors
//   stage_bit()    : one-hot mask for a boundary index
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam int IF_ID          = 0;
    localparam int ID_EX          = 1;
    localparam int EX_MEM         = 2;
    localparam int MEM_WB         = 3;
    localparam int NUM_BOUNDARIES = 4;

    localparam logic [NUM_BOUNDARIES-1:0] ALL_BOUNDARIES = '1;

    function automatic logic [NUM_BOUNDARIES-1:0] stage_bit(input int idx);
        logic [NUM_BOUNDARIES-1:0] m;
        m = '0;
        m[idx] = 1'b1;
        return m;
    endfunction

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter.
//   clk, rst_n : clock, asynchronous active-low reset (clears count)
//   en         : count one when high
//   count      : current value; sticks at all-ones instead of wrapping
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [WIDTH-1:0] count
);

    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (en && (count_reg != {WIDTH{1'b1}})) begin
            count_reg <= count_reg + WIDTH'(1);
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard/redirect controller.
//   clk, rst_n        : clock, asynchronous active-low reset
//   load_use_i        : load-use hazard in ID
//   ex_busy_i         : multi-cycle EX op in progress
//   mem_busy_i        : MEM waiting on data memory
//   branch_taken_i    : taken branch resolved in EX, target on branch_target_i
//   trap_i            : exception/interrupt from WB, handler on trap_vec_i
//   ok_o / flush_o    : per-boundary load enable / bubble insert (bit0 IF/ID .. bit3 MEM/WB)
//   pc_hold_o         : freeze fetch PC
//   redirect_valid_o  : registered one-cycle pulse, fetch loads redirect_pc_o
//   redirect_pc_o     : redirect target, zero when no redirect
//   stall_cnt_o       : saturating count of pc_hold_o cycles
// Event priority: trap > mem_busy > ex_busy > branch_taken > load_use.
module pipe_ctrl
    import pipe_pkg::*;
#(
    parameter int DATA_SIZE    = 32,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_use_i,
    input  logic                 ex_busy_i,
    input  logic                 mem_busy_i,
    input  logic                 branch_taken_i,
    input  logic [DATA_SIZE-1:0] branch_target_i,
    input  logic                 trap_i,
    input  logic [DATA_SIZE-1:0] trap_vec_i,
    output logic [3:0]           ok_o,
    output logic [3:0]           flush_o,
    output logic                 pc_hold_o,
    output logic                 redirect_valid_o,
    output logic [DATA_SIZE-1:0] redirect_pc_o,
    output logic [DATA_SIZE-1:0] stall_cnt_o
);

    localparam int DCW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

    state_t               state_reg, state_next;
    logic [DCW-1:0]       drain_reg, drain_next;
    logic [DATA_SIZE-1:0] vec_reg, vec_next;
    logic                 redir_valid_reg, redir_valid_next;
    logic [DATA_SIZE-1:0] redir_pc_reg, redir_pc_next;

    logic [3:0] ok_c;
    logic [3:0] flush_c;
    logic       hold_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_RUN;
            drain_reg       <= '0;
            vec_reg         <= '0;
            redir_valid_reg <= 1'b0;
            redir_pc_reg    <= '0;
        end else begin
            state_reg       <= state_next;
            drain_reg       <= drain_next;
            vec_reg         <= vec_next;
            redir_valid_reg <= redir_valid_next;
            redir_pc_reg    <= redir_pc_next;
        end
    end

    always_comb begin
        state_next       = state_reg;
        drain_next       = drain_reg;
        vec_next         = vec_reg;
        redir_valid_next = 1'b0;
        redir_pc_next    = '0;
        ok_c             = ALL_BOUNDARIES;
        flush_c          = '0;
        hold_c           = 1'b0;

        if (trap_i) begin
            // Trap wins over everything, including a same-cycle branch, so
            // no branch redirect is scheduled. Also restarts an ongoing drain.
            ok_c       = ALL_BOUNDARIES;
            flush_c    = ALL_BOUNDARIES;
            hold_c     = 1'b1;
            drain_next = DCW'(DRAIN_CYCLES);
            vec_next   = trap_vec_i;
            state_next = ST_DRAIN;
        end else if (state_reg == ST_DRAIN) begin
            ok_c    = ALL_BOUNDARIES;
            flush_c = ALL_BOUNDARIES;
            hold_c  = 1'b1;
            if (drain_reg > DCW'(0)) begin
                drain_next = drain_reg - DCW'(1);
            end
            // Leaving as the counter reaches zero; the pulse lands on the
            // first RUN cycle.
            if (drain_reg <= DCW'(1)) begin
                state_next       = ST_RUN;
                redir_valid_next = 1'b1;
                redir_pc_next    = vec_reg;
            end
        end else if (mem_busy_i) begin
            ok_c       = '0;
            hold_c     = 1'b1;
            state_next = ST_STALL;
        end else if (ex_busy_i) begin
            // Only MEM/WB advances, carrying a bubble into WB.
            ok_c       = stage_bit(MEM_WB);
            flush_c    = stage_bit(MEM_WB);
            hold_c     = 1'b1;
            state_next = ST_STALL;
        end else begin
            // RUN, or the first non-busy cycle of STALL which behaves as RUN.
            // A branch seen while busy was ignored above; EX re-presents it.
            state_next = ST_RUN;
            if (branch_taken_i) begin
                flush_c          = stage_bit(IF_ID) | stage_bit(ID_EX);
                redir_valid_next = 1'b1;
                redir_pc_next    = branch_target_i;
            end else if (load_use_i) begin
                ok_c    = ALL_BOUNDARIES & ~stage_bit(IF_ID);
                flush_c = stage_bit(ID_EX);
                hold_c  = 1'b1;
            end
        end
    end

    // While reset is held every boundary inserts a bubble and nothing loads.
    assign ok_o             = rst_n ? ok_c : 4'b0000;
    assign flush_o          = rst_n ? flush_c : 4'b1111;
    assign pc_hold_o        = rst_n ? hold_c : 1'b1;
    assign redirect_valid_o = redir_valid_reg;
    assign redirect_pc_o    = redir_pc_reg;

    sat_counter #(
        .WIDTH (DATA_SIZE)
    ) u_stall_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pc_hold_o),
        .count (stall_cnt_o)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        load_use, ex_busy, mem_busy, br_taken, trap;
    logic [31:0] br_tgt, trap_vec;

    logic [3:0]  ok, flush;
    logic        hold, rv;
    logic [31:0] rpc, scnt;

    logic [3:0]  ok4, flush4;
    logic        hold4, rv4;
    logic [3:0]  rpc4, scnt4;

    int checks   = 0;
    int failures = 0;
    int step_no  = 0;
    int hold_model = 0;

    typedef struct {
        logic        rv;
        logic [31:0] pc;
    } redir_t;
    redir_t rq[$];

    always #5 clk = ~clk;

    pipe_ctrl #(.DATA_SIZE(32), .DRAIN_CYCLES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .load_use_i(load_use), .ex_busy_i(ex_busy), .mem_busy_i(mem_busy),
        .branch_taken_i(br_taken), .branch_target_i(br_tgt),
        .trap_i(trap), .trap_vec_i(trap_vec),
        .ok_o(ok), .flush_o(flush), .pc_hold_o(hold),
        .redirect_valid_o(rv), .redirect_pc_o(rpc), .stall_cnt_o(scnt)
    );

    pipe_ctrl #(.DATA_SIZE(4), .DRAIN_CYCLES(2)) dut4 (
        .clk(clk), .rst_n(rst_n),
        .load_use_i(load_use), .ex_busy_i(ex_busy), .mem_busy_i(mem_busy),
        .branch_taken_i(br_taken), .branch_target_i(br_tgt[3:0]),
        .trap_i(trap), .trap_vec_i(trap_vec[3:0]),
        .ok_o(ok4), .flush_o(flush4), .pc_hold_o(hold4),
        .redirect_valid_o(rv4), .redirect_pc_o(rpc4), .stall_cnt_o(scnt4)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL step=%0d %s observed=%0h expected=%0h", step_no, tag, obs, exp);
        end
    endtask

    task automatic clear_inputs();
        load_use = 0; ex_busy = 0; mem_busy = 0; br_taken = 0; trap = 0;
        br_tgt = '0; trap_vec = '0;
    endtask

    // One clock cycle: drive inputs, push the redirect this cycle should cause
    // for the next cycle, then pop and compare at the falling edge.
    task automatic step(input logic lu, input logic eb, input logic mb,
                        input logic bt, input logic [31:0] tgt,
                        input logic tp, input logic [31:0] vec,
                        input logic [3:0] e_ok, input logic [3:0] e_flush, input logic e_hold,
                        input logic n_rv, input logic [31:0] n_pc);
        redir_t cur, nxt;
        int     sat4;
        @(posedge clk);
        #1;
        load_use = lu; ex_busy = eb; mem_busy = mb;
        br_taken = bt; br_tgt = tgt; trap = tp; trap_vec = vec;
        nxt.rv = n_rv;
        nxt.pc = n_pc;
        rq.push_back(nxt);
        @(negedge clk);
        step_no++;
        if (rq.size() < 2) begin
            checks++;
            failures++;
            $display("FAIL step=%0d scoreboard underflow observed=%0d expected=2", step_no, rq.size());
            cur.rv = 1'b0;
            cur.pc = '0;
        end else begin
            cur = rq.pop_front();
        end
        sat4 = (hold_model > 15) ? 15 : hold_model;
        chk("ok", 32'(ok), 32'(e_ok));
        chk("flush", 32'(flush), 32'(e_flush));
        chk("pc_hold", 32'(hold), 32'(e_hold));
        chk("redirect_valid", 32'(rv), 32'(cur.rv));
        chk("redirect_pc", rpc, cur.pc);
        chk("stall_cnt", scnt, 32'(hold_model));
        chk("stall_cnt4", 32'(scnt4), 32'(sat4));
        $display("step %0d lu=%b eb=%b mb=%b bt=%b tp=%b ok=%b flush=%b hold=%b rv=%b rpc=%h scnt=%0d scnt4=%0d",
                 step_no, lu, eb, mb, bt, tp, ok, flush, hold, rv, rpc, scnt, scnt4);
        if (e_hold) hold_model++;
    endtask

    task automatic reset_scoreboard();
        redir_t z;
        z.rv = 1'b0;
        z.pc = '0;
        rq.delete();
        rq.push_back(z);
        hold_model = 0;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_ok"}, 32'(ok), 32'h0);
        chk({tag, "_flush"}, 32'(flush), 32'hF);
        chk({tag, "_rv"}, 32'(rv), 32'h0);
        chk({tag, "_rpc"}, rpc, 32'h0);
        chk({tag, "_scnt"}, scnt, 32'h0);
        chk({tag, "_scnt4"}, 32'(scnt4), 32'h0);
        $display("reset check %s ok=%b flush=%b rv=%b scnt=%0d", tag, ok, flush, rv, scnt);
    endtask

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("por");
        rst_n = 1'b1;
        reset_scoreboard();

        // Idle RUN, then load-use bubble and recovery
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b0000,0, 0,32'h0);
        step(1,0,0, 0,32'h0, 0,32'h0, 4'b1110,4'b0010,1, 0,32'h0);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b0000,0, 0,32'h0);
        // Taken branch to 0x100, redirect on the following cycle
        step(0,0,0, 1,32'h100, 0,32'h0, 4'b1111,4'b0011,0, 1,32'h100);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b0000,0, 0,32'h0);
        // mem_busy with ex_busy for three cycles, RUN on the fourth
        repeat (3) step(0,1,1, 0,32'h0, 0,32'h0, 4'b0000,4'b0000,1, 0,32'h0);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b0000,0, 0,32'h0);
        // ex_busy alone; branch during stall ignored, honoured on exit cycle
        step(0,1,0, 0,32'h0, 0,32'h0, 4'b1000,4'b1000,1, 0,32'h0);
        step(0,1,0, 1,32'h300, 0,32'h0, 4'b1000,4'b1000,1, 0,32'h0);
        step(0,0,0, 1,32'h200, 0,32'h0, 4'b1111,4'b0011,0, 1,32'h200);
        // Trap with same-cycle branch: three flush cycles, single trap redirect
        step(0,0,0, 1,32'h400, 1,32'h8000_0000, 4'b1111,4'b1111,1, 0,32'h0);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b1111,1, 0,32'h0);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b1111,1, 1,32'h8000_0000);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b0000,0, 0,32'h0);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b0000,0, 0,32'h0);
        // Trap during DRAIN restarts the count and replaces the vector
        step(0,0,0, 0,32'h0, 1,32'h1000, 4'b1111,4'b1111,1, 0,32'h0);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b1111,1, 0,32'h0);
        step(0,0,0, 0,32'h0, 1,32'h2000, 4'b1111,4'b1111,1, 0,32'h0);
        step(0,1,1, 0,32'h0, 0,32'h0, 4'b1111,4'b1111,1, 0,32'h0);
        step(0,0,0, 1,32'h500, 0,32'h0, 4'b1111,4'b1111,1, 1,32'h2000);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b0000,0, 0,32'h0);
        // mem_busy outranks load_use
        step(1,0,1, 0,32'h0, 0,32'h0, 4'b0000,4'b0000,1, 0,32'h0);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b0000,0, 0,32'h0);
        // Long stall: 4-bit counter saturates at 0xF and holds
        repeat (20) step(0,0,1, 0,32'h0, 0,32'h0, 4'b0000,4'b0000,1, 0,32'h0);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b0000,0, 0,32'h0);
        // Reset asserted in the middle of DRAIN
        step(0,0,0, 0,32'h0, 1,32'h9000, 4'b1111,4'b1111,1, 0,32'h0);
        step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b1111,1, 0,32'h0);
        clear_inputs();
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("mid_drain");
        @(posedge clk);
        @(negedge clk);
        chk_reset_outputs("mid_drain_held");
        rst_n = 1'b1;
        reset_scoreboard();
        repeat (3) step(0,0,0, 0,32'h0, 0,32'h0, 4'b1111,4'b0000,0, 0,32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter DATA_SIZE, default 32; width of PC/target buses and the stall counter.
REQ-002 Parameter DRAIN_CYCLES, default 2; cycles all stages are flushed on a trap before the redirect.
REQ-003 clk  input  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 load_use_i  input  1  ID needs a result still in EX (load).
REQ-006 ex_busy_i  input  1  multi-cycle EX operation not finished.
REQ-007 mem_busy_i  input  1  MEM stage waiting on data memory.
REQ-008 branch_taken_i  input  1  EX resolved a taken branch/jump this cycle.
REQ-009 branch_target_i  input  DATA_SIZE  target PC qualified by branch_taken_i.
REQ-010 trap_i  input  1  WB raises an exception/interrupt this cycle.
REQ-011 trap_vec_i  input  DATA_SIZE  trap handler PC qualified by trap_i.
REQ-012 ok_o  output  4  per-boundary load enable; bit0 IF/ID, bit1 ID/EX, bit2 EX/MEM, bit3 MEM/WB.
REQ-013 flush_o  output  4  per-boundary bubble insert, same bit order; meaningful only with the matching ok_o bit.
REQ-014 pc_hold_o  output  1  fetch PC shall not advance.
REQ-015 redirect_valid_o  output  1  registered one-cycle pulse: fetch loads redirect_pc_o.
REQ-016 redirect_pc_o  output  DATA_SIZE  redirect target; 0 when redirect_valid_o is low.
REQ-017 stall_cnt_o  output  DATA_SIZE  saturating count of cycles with pc_hold_o high.

Function
REQ-018 FSM states RUN, STALL, DRAIN; priority among simultaneous inputs: trap > mem_busy > ex_busy > branch_taken > load_use.
REQ-019 RUN, no event: ok_o=4'b1111, flush_o=4'b0000, pc_hold_o=0.
REQ-020 RUN + load_use_i only: ok_o=4'b1110, flush_o=4'b0010, pc_hold_o=1; no state change (one-cycle bubble).
REQ-021 RUN + branch_taken_i (no higher event): ok_o=4'b1111, flush_o=4'b0011; next cycle redirect_valid_o=1, redirect_pc_o=registered branch_target_i.
REQ-022 mem_busy_i or ex_busy_i in RUN/STALL: go/stay STALL; mem_busy: ok_o=4'b0000, pc_hold_o=1; ex_busy only: ok_o=4'b1000, flush_o=4'b1000 (bubble into WB), pc_hold_o=1.
REQ-023 STALL exits to RUN in the first cycle both busy inputs are low; that cycle follows RUN rules.
REQ-024 branch_taken_i during STALL is ignored; EX re-presents it after the stall.
REQ-025 trap_i in any state: ok_o=4'b1111, flush_o=4'b1111, pc_hold_o=1, drain counter loaded with DRAIN_CYCLES, trap_vec_i registered, go DRAIN.
REQ-026 DRAIN: all stages flushed, pc_hold_o=1, counter decrements; at 0, return to RUN and pulse redirect_valid_o with the trap vector.
REQ-027 trap_i during DRAIN restarts the counter and replaces the stored vector.
REQ-028 At most one redirect per cycle; a trap cancels a pending branch redirect.
REQ-029 stall_cnt_o increments by 1 per pc_hold_o cycle, saturates at all-ones, never wraps.

Reset
REQ-030 rst_n low: state RUN, drain counter 0, stall_cnt_o 0, redirect_valid_o 0, redirect_pc_o 0; ok_o=4'b0000, flush_o=4'b1111 while reset asserted.
REQ-031 Reset mid-DRAIN or STALL aborts the operation; no redirect pulse follows reset release.

Structure
REQ-032 Shared package pipe_pkg holds the state enum and boundary index constants IF_ID=0, ID_EX=1, EX_MEM=2, MEM_WB=3.
REQ-033 Saturating counter implemented as sub-module sat_counter, parameterised by width.

Verification
REQ-034 load_use_i=1 one cycle in RUN -> ok_o=1110, flush_o=0010, pc_hold_o=1 that cycle; 1111/0000 next.
REQ-035 branch_taken_i=1, target 0x0000_0100 -> flush_o=0011; next cycle redirect_valid_o=1, redirect_pc_o=0x100.
REQ-036 mem_busy_i high 3 cycles with ex_busy_i high -> ok_o=0000 for 3 cycles, stall_cnt_o +3, RUN on cycle 4.
REQ-037 trap_i with branch_taken_i same cycle, vec 0x8000_0000, DRAIN_CYCLES=2 -> flush_o=1111 for 3 cycles, single redirect to 0x8000_0000, no branch redirect.
REQ-038 stall_cnt_o forced to all-ones via stalls (DATA_SIZE=4) -> holds 0xF, no wrap.
REQ-039 rst_n asserted during DRAIN -> outputs at reset values, no redirect_valid_o after release.
